// File: rtl/sys_array_feeder.sv
// sys_array_feeder: holds two 4x4 operand matrices (A and B) and, on each
// start request, streams them into a 4x4 output-stationary systolic array
// with the diagonal skew the array expects. Row i of A enters array row i
// delayed by i cycles; column j of B enters array column j delayed by j
// cycles. The block only moves operands; it performs no arithmetic.
module sys_array_feeder #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic            ld_sel,
    input  logic [1:0]      ld_row,
    input  logic [4*DW-1:0] ld_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            arr_clr,
    output logic [DW-1:0]   a1,
    output logic [DW-1:0]   a2,
    output logic [DW-1:0]   a3,
    output logic [DW-1:0]   a4,
    output logic [DW-1:0]   b1,
    output logic [DW-1:0]   b2,
    output logic [DW-1:0]   b3,
    output logic [DW-1:0]   b4
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        DONE
    } state_t;

    // Last feed cycle: t runs 0..9, enough for the skewed wavefront to
    // cover all 4 rows, 4 columns and 4 inner-product terms.
    localparam logic [3:0] T_LAST = 4'd9;

    state_t      state;
    logic [3:0]  t;

    // mat_a[i][k] = A[i][k], mat_b[k][j] = B[k][j]
    logic [DW-1:0] mat_a [4][4];
    logic [DW-1:0] mat_b [4][4];

    // Registered skewed operands, index 0..3 maps to a1..a4 / b1..b4.
    logic [DW-1:0] a_q [4];
    logic [DW-1:0] b_q [4];

    // Operand for array row `row` at feed cycle tt: A[row][tt-row], or 0
    // outside the 4-cycle window of that row.
    function automatic logic [DW-1:0] a_tap(input logic [3:0] tt, input int row);
        int            k;
        logic [DW-1:0] res;
        res = '0;
        k   = int'(tt) - row;
        if (k >= 0 && k <= 3) begin
            res = mat_a[row[1:0]][k[1:0]];
        end
        return res;
    endfunction

    // Operand for array column `col` at feed cycle tt: B[tt-col][col], or 0
    // outside the 4-cycle window of that column.
    function automatic logic [DW-1:0] b_tap(input logic [3:0] tt, input int col);
        int            k;
        logic [DW-1:0] res;
        res = '0;
        k   = int'(tt) - col;
        if (k >= 0 && k <= 3) begin
            res = mat_b[k[1:0]][col[1:0]];
        end
        return res;
    endfunction

    // Matrix row storage: a row is written only while the feeder is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand storage is cleared on reset on purpose, so a
            // pass started before any load feeds zeros rather than stale rows.
            for (int i = 0; i < 4; i++) begin
                for (int k = 0; k < 4; k++) begin
                    mat_a[i][k] <= '0;
                    mat_b[i][k] <= '0;
                end
            end
        end else if (ld_valid && ld_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (ld_sel) begin
                    mat_b[ld_row][k] <= ld_data[DW*k +: DW];
                end else begin
                    mat_a[ld_row][k] <= ld_data[DW*k +: DW];
                end
            end
        end
    end

    // Pass sequencer: IDLE -> CLEAR (1) -> FEED (10) -> DONE (1) -> IDLE,
    // with every output registered so it is valid for the whole cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            t        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            arr_clr  <= 1'b0;
            ld_ready <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples pre-edge values; the defaults below make the
            // pulses and operands drop to 0 unless a state re-asserts them.
            done    <= 1'b0;
            arr_clr <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        ld_ready <= 1'b0;
                        arr_clr  <= 1'b1;
                    end
                end

                CLEAR: begin
                    state <= FEED;
                    t     <= '0;
                    for (int i = 0; i < 4; i++) begin
                        a_q[i] <= a_tap(4'd0, i);
                        b_q[i] <= b_tap(4'd0, i);
                    end
                end

                FEED: begin
                    if (t == T_LAST) begin
                        state <= DONE;
                        t     <= '0;
                        done  <= 1'b1;
                    end else begin
                        t <= t + 4'd1;
                        for (int i = 0; i < 4; i++) begin
                            a_q[i] <= a_tap(t + 4'd1, i);
                            b_q[i] <= b_tap(t + 4'd1, i);
                        end
                    end
                end

                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ld_ready <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    t        <= '0;
                    busy     <= 1'b0;
                    ld_ready <= 1'b1;
                end
            endcase
        end
    end

    assign a1 = a_q[0];
    assign a2 = a_q[1];
    assign a3 = a_q[2];
    assign a4 = a_q[3];
    assign b1 = b_q[0];
    assign b2 = b_q[1];
    assign b3 = b_q[2];
    assign b4 = b_q[3];

endmodule

// File: tb/tb_sys_array_feeder.sv
// Bench for sys_array_feeder: a model of the A/B storage predicts the
// per-cycle outputs of each pass into a queue, which is popped and compared
// cycle by cycle; a behavioural 4x4 systolic array driven by the feeder
// outputs provides the matrix products checked at done.
module tb_sys_array_feeder;

    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            ld_valid;
    logic            ld_ready;
    logic            ld_sel;
    logic [1:0]      ld_row;
    logic [4*DW-1:0] ld_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            arr_clr;
    logic [DW-1:0]   a1, a2, a3, a4, b1, b2, b3, b4;

    sys_array_feeder #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_sel   (ld_sel),
        .ld_row   (ld_row),
        .ld_data  (ld_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .arr_clr  (arr_clr),
        .a1       (a1),
        .a2       (a2),
        .a3       (a3),
        .a4       (a4),
        .b1       (b1),
        .b2       (b2),
        .b3       (b3),
        .b4       (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                busy;
        logic                done;
        logic                clr;
        logic                rdy;
        logic [3:0][DW-1:0]  a;
        logic [3:0][DW-1:0]  b;
    } obs_t;

    int   n_checks = 0;
    int   n_errors = 0;
    obs_t exp_q[$];

    // Reference copy of the matrices the DUT should hold.
    logic [DW-1:0] ma [4][4];
    logic [DW-1:0] mb [4][4];

    // Behavioural output-stationary systolic array; arr_clr is its reset.
    logic [DW-1:0] av [4];
    logic [DW-1:0] bv [4];
    logic [DW-1:0] pa [4][4];
    logic [DW-1:0] pb [4][4];
    logic [DW-1:0] acc [4][4];

    assign av[0] = a1;
    assign av[1] = a2;
    assign av[2] = a3;
    assign av[3] = a4;
    assign bv[0] = b1;
    assign bv[1] = b2;
    assign bv[2] = b3;
    assign bv[3] = b4;

    always @(posedge clk) begin
        logic [DW-1:0] ain, bin;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ain = (j == 0) ? av[i] : pa[i][j-1];
                bin = (i == 0) ? bv[j] : pb[i-1][j];
                if (arr_clr) begin
                    acc[i][j] <= '0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + ain * bin;
                    pa[i][j]  <= ain;
                    pb[i][j]  <= bin;
                end
            end
        end
    end

    function automatic obs_t observe();
        obs_t o;
        o.busy = busy;
        o.done = done;
        o.clr  = arr_clr;
        o.rdy  = ld_ready;
        o.a    = {a4, a3, a2, a1};
        o.b    = {b4, b3, b2, b1};
        return o;
    endfunction

    function automatic obs_t idle_exp();
        obs_t e;
        e      = '0;
        e.rdy  = 1'b1;
        return e;
    endfunction

    // Expected outputs for pass cycle idx: 0 = CLEAR, 1..10 = FEED t=idx-1,
    // 11 = DONE.
    function automatic obs_t pass_exp(input int idx);
        obs_t e;
        int   t;
        e      = '0;
        e.busy = 1'b1;
        if (idx == 0) begin
            e.clr = 1'b1;
        end else if (idx == 11) begin
            e.done = 1'b1;
        end else begin
            t = idx - 1;
            for (int i = 0; i < 4; i++) begin
                if (t - i >= 0 && t - i <= 3) begin
                    e.a[i] = ma[i][t-i];
                    e.b[i] = mb[t-i][i];
                end
            end
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                ma[i][k] = '0;
                mb[i][k] = '0;
            end
        end
    endtask

    // Entered and left at a falling edge.
    task automatic check_idle(input string name);
        obs_t got;
        @(negedge clk);
        got = observe();
        n_checks++;
        if (got !== idle_exp()) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, idle_exp());
        end
    endtask

    // Write one row in IDLE; the model follows the write.
    task automatic load_row(input logic sel, input int row, input logic [4*DW-1:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_row   = row[1:0];
        ld_data  = data;
        @(negedge clk);
        ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sel) mb[row][k] = data[DW*k +: DW];
            else     ma[row][k] = data[DW*k +: DW];
        end
    endtask

    // One pass from an IDLE falling edge. Optional: a row write in the start
    // cycle, a start pulse / row write / reset at pass cycle *_at.
    task automatic do_pass(input string name, input bit ld_first, input logic sel,
                           input int row, input logic [4*DW-1:0] data,
                           input int start_at, input int ld_at, input int rst_at);
        obs_t          got, e;
        logic [DW-1:0] exp_c;
        bit            aborted;
        aborted = 1'b0;
        start   = 1'b1;
        if (ld_first) begin
            ld_valid = 1'b1;
            ld_sel   = sel;
            ld_row   = row[1:0];
            ld_data  = data;
            for (int k = 0; k < 4; k++) begin
                if (sel) mb[row][k] = data[DW*k +: DW];
                else     ma[row][k] = data[DW*k +: DW];
            end
        end
        for (int idx = 0; idx < 12; idx++) exp_q.push_back(pass_exp(idx));

        for (int idx = 0; idx < 12; idx++) begin
            if (!aborted) begin
                @(negedge clk);
                start    = 1'b0;
                ld_valid = 1'b0;
                e   = exp_q.pop_front();
                got = observe();
                n_checks++;
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL %s cycle %0d: got %h expected %h", name, idx, got, e);
                end
                if (idx == 11) begin
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            exp_c = '0;
                            for (int k = 0; k < 4; k++) exp_c = exp_c + ma[i][k] * mb[k][j];
                            n_checks++;
                            if (acc[i][j] !== exp_c) begin
                                n_errors++;
                                $display("FAIL %s c%0d: got %0d expected %0d",
                                         name, 4*i+j+1, acc[i][j], exp_c);
                            end
                        end
                    end
                end
                if (idx == start_at) start = 1'b1;
                if (idx == ld_at) begin
                    ld_valid = 1'b1;
                    ld_sel   = 1'($urandom_range(0, 1));
                    ld_row   = 2'($urandom_range(0, 3));
                    ld_data  = {$urandom, $urandom, $urandom, $urandom};
                end
                if (idx == rst_at) begin
                    rst     = 1'b1;
                    aborted = 1'b1;
                    exp_q.delete();
                    clear_model();
                end
            end
        end

        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
            got = observe();
            n_checks++;
            if (got !== idle_exp()) begin
                n_errors++;
                $display("FAIL %s after reset: got %h expected %h", name, got, idle_exp());
            end
            for (int n = 0; n < 4; n++) check_idle({name, " no done"});
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_sel   = 1'b0;
        ld_row   = 2'd0;
        ld_data  = '1;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        start    = 1'b0;
        ld_valid = 1'b0;
        clear_model();
        check_idle("reset state");
        check_idle("reset state hold");
        do_pass("zero pass", 1'b0, 1'b0, 0, '0, -1, -1, -1);
        check_idle("zero pass end");
    endtask

    task automatic test_identity();
        for (int i = 0; i < 4; i++) begin
            load_row(1'b0, i, {DW'(i == 3), DW'(i == 2), DW'(i == 1), DW'(i == 0)});
            load_row(1'b1, i, {DW'(4*i+4), DW'(4*i+3), DW'(4*i+2), DW'(4*i+1)});
        end
        check_idle("identity loaded");
        do_pass("identity", 1'b0, 1'b0, 0, '0, -1, -1, -1);
        check_idle("identity end");
    endtask

    task automatic test_all_ones();
        logic [4*DW-1:0] ones;
        ones = {DW'(1), DW'(1), DW'(1), DW'(1)};
        for (int i = 0; i < 4; i++) load_row(1'b0, i, ones);
        for (int i = 0; i < 3; i++) load_row(1'b1, i, ones);
        // Last row written in the same cycle as start.
        do_pass("all ones", 1'b1, 1'b1, 3, ones, -1, -1, -1);
        check_idle("all ones end");
    endtask

    task automatic test_pattern();
        for (int i = 0; i < 4; i++)
            load_row(1'b0, i, {DW'(10*i+3), DW'(10*i+2), DW'(10*i+1), DW'(10*i)});
        do_pass("pattern", 1'b0, 1'b0, 0, '0, -1, -1, -1);
        check_idle("pattern end");
    endtask

    task automatic test_back_to_back();
        do_pass("start in feed", 1'b0, 1'b0, 0, '0, 4, -1, -1);
        check_idle("between passes");
        do_pass("back to back", 1'b0, 1'b0, 0, '0, -1, -1, -1);
        check_idle("back to back end");
    endtask

    task automatic test_busy_write();
        do_pass("write while busy", 1'b0, 1'b0, 0, '0, -1, 3, -1);
        check_idle("busy write end");
        do_pass("after busy write", 1'b0, 1'b0, 0, '0, -1, -1, -1);
        check_idle("after busy write end");
    endtask

    task automatic test_reset_mid();
        do_pass("reset mid feed", 1'b0, 1'b0, 0, '0, -1, -1, 6);
        for (int i = 0; i < 4; i++) begin
            load_row(1'b0, i, {$urandom, $urandom, $urandom, $urandom});
            load_row(1'b1, i, {$urandom, $urandom, $urandom, $urandom});
        end
        do_pass("after reset reload", 1'b0, 1'b0, 0, '0, -1, -1, -1);
        check_idle("reset mid end");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        ld_valid = 1'b0;
        ld_sel   = 1'b0;
        ld_row   = 2'd0;
        ld_data  = '0;
        clear_model();
        test_reset();
        test_identity();
        test_all_ones();
        test_pattern();
        test_back_to_back();
        test_busy_write();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
